// File: rtl/mips_avalon_pkg.sv
// Shared types and widths for the MIPS instruction/data Avalon arbiter.
package mips_avalon_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  // Instruction fetches are always full-word reads.
  localparam logic [BE_W-1:0] BE_ALL = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mips_avalon_arb_wdog.sv
// Per-transaction waitrequest counter and sticky timeout flag for the arbiter.
module mips_avalon_arb_wdog #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_wait,
  output logic o_timeout
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      // The flag lags the counter by one edge and never clears outside reset.
      if (r_cnt == CNT_MAX) begin
        r_timeout <= 1'b1;
      end
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_wait && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_timeout = r_timeout;

endmodule

// File: rtl/mips_avalon_arbiter.sv
// Arbitrates a MIPS instruction-fetch port and data port onto one Avalon master.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is data-first.
module mips_avalon_arbiter
  import mips_avalon_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction-fetch requester
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic              i_waitrequest,
  output logic [DATA_W-1:0] i_readdata,
  // data requester
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [DATA_W-1:0] d_writedata,
  input  logic [BE_W-1:0]   d_byteenable,
  output logic              d_waitrequest,
  output logic [DATA_W-1:0] d_readdata,
  // shared master
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  output logic [BE_W-1:0]   m_byteenable,
  input  logic              m_waitrequest,
  input  logic [DATA_W-1:0] m_readdata,
  output logic              timeout_err
);

  arb_state_e        r_state;
  arb_state_e        w_state_next;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              w_i_req;
  logic              w_d_req;
  logic              w_pick_d;
  logic              w_grant_start;
  logic              w_wait;
  logic              w_timeout;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_i;

  // On a tie, serve whichever side did not get the previous grant.
  assign w_pick_d = r_last_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_i <= 1'b1;
    end else if (w_grant_start) begin
      r_last_i <= (w_state_next == GRANT_I);
    end
  end
`else
  assign w_pick_d = 1'b1;
`endif

  always_comb begin
    w_state_next  = r_state;
    m_address     = '0;
    m_read        = 1'b0;
    m_write       = 1'b0;
    m_writedata   = '0;
    m_byteenable  = '0;
    i_waitrequest = w_i_req;
    d_waitrequest = w_d_req;
    i_readdata    = r_i_rdata;
    d_readdata    = r_d_rdata;

    case (r_state)
      IDLE: begin
        if (w_i_req && w_d_req) begin
          w_state_next = w_pick_d ? GRANT_D : GRANT_I;
        end else if (w_d_req) begin
          w_state_next = GRANT_D;
        end else if (w_i_req) begin
          w_state_next = GRANT_I;
        end
      end

      GRANT_I: begin
        m_address     = i_address;
        m_read        = i_read;
        m_byteenable  = BE_ALL;
        i_waitrequest = m_waitrequest;
        i_readdata    = m_readdata;
        // Release on completion, or when the requester abandons the access.
        if (!w_i_req || !m_waitrequest) begin
          w_state_next = IDLE;
        end
      end

      GRANT_D: begin
        m_address     = d_address;
        m_read        = d_read;
        m_write       = d_write;
        m_writedata   = d_writedata;
        m_byteenable  = d_byteenable;
        d_waitrequest = m_waitrequest;
        d_readdata    = m_readdata;
        if (!w_d_req || !m_waitrequest) begin
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == GRANT_I) begin
        r_i_rdata <= m_readdata;
      end
      if (r_state == GRANT_D) begin
        r_d_rdata <= m_readdata;
      end
    end
  end

  assign w_grant_start = (r_state == IDLE) && (w_state_next != IDLE);
  assign w_wait        = (r_state != IDLE) && m_waitrequest;

  mips_avalon_arb_wdog #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_grant_start),
    .i_wait    (w_wait),
    .o_timeout (w_timeout)
  );

  assign timeout_err = w_timeout;

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a grant-owner model.
module tb_mips_avalon_arbiter;

  localparam int MAXW = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_address = '0;
  logic        i_read = 1'b0;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  logic [31:0] d_address = '0;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_writedata = '0;
  logic [3:0]  d_byteenable = '0;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  mips_avalon_arbiter #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- memory slave (environment) ----------------
  logic [31:0] mem [0:255];
  int  s_cnt = 0;
  int  slave_delay = 0;
  int  s_rdelay = 0;
  bit  delay_rand = 1'b0;
  int  cur_delay;
  wire s_active = m_read | m_write;

  assign cur_delay     = delay_rand ? s_rdelay : slave_delay;
  assign m_waitrequest = s_active && (s_cnt < cur_delay);
  assign m_readdata    = mem[m_address[9:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cnt <= 0;
    end else if (s_active && m_waitrequest) begin
      s_cnt <= s_cnt + 1;
    end else begin
      s_cnt <= 0;
      if (s_active) s_rdelay <= $urandom_range(0, 3);
      if (m_write) begin
        for (int b = 0; b < 4; b++)
          if (m_byteenable[b]) mem[m_address[9:2]][8*b +: 8] <= m_writedata[8*b +: 8];
      end
    end
  end

  // ---------------- behavioural model ----------------
  // owner: 0 = nobody, 1 = instruction side, 2 = data side
  int          owner = 0, owner_n = 0;
  bit          last_i = 1'b1, last_i_n = 1'b1;
  int          wcnt = 0, wcnt_n = 0;
  bit          to = 1'b0, to_n = 1'b0;
  logic [31:0] hold_i = '0, hold_i_n = '0, hold_d = '0, hold_d_n = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner = 0; last_i = 1'b1; wcnt = 0; to = 1'b0; hold_i = '0; hold_d = '0;
    end else begin
      owner = owner_n; last_i = last_i_n; wcnt = wcnt_n; to = to_n;
      hold_i = hold_i_n; hold_d = hold_d_n;
    end
  end

  always @(negedge clk) begin : cmp
    logic [31:0] e_addr, e_wd, e_ird, e_drd;
    logic [3:0]  e_be;
    logic        e_rd, e_wr, e_iw, e_dw, e_mw, dreq, ireq;
    int          nx;
    if (rst_n) begin
      dreq = d_read | d_write;
      ireq = i_read;
      e_addr = '0; e_wd = '0; e_be = '0; e_rd = 1'b0; e_wr = 1'b0; e_mw = 1'b0;
      e_iw = ireq; e_dw = dreq; e_ird = hold_i; e_drd = hold_d;
      if (owner == 1) begin
        e_addr = i_address; e_rd = i_read; e_be = 4'hF;
        e_mw = e_rd && (s_cnt < cur_delay);
        e_iw = e_mw; e_ird = mem[e_addr[9:2]];
      end else if (owner == 2) begin
        e_addr = d_address; e_rd = d_read; e_wr = d_write; e_wd = d_writedata; e_be = d_byteenable;
        e_mw = (e_rd || e_wr) && (s_cnt < cur_delay);
        e_dw = e_mw; e_drd = mem[e_addr[9:2]];
      end
      if (chk_en) begin
        chk("m_address", m_address, e_addr);
        chk("m_read", 32'(m_read), 32'(e_rd));
        chk("m_write", 32'(m_write), 32'(e_wr));
        chk("m_writedata", m_writedata, e_wd);
        chk("m_byteenable", 32'(m_byteenable), 32'(e_be));
        chk("i_waitrequest", 32'(i_waitrequest), 32'(e_iw));
        chk("d_waitrequest", 32'(d_waitrequest), 32'(e_dw));
        chk("i_readdata", i_readdata, e_ird);
        chk("d_readdata", d_readdata, e_drd);
        chk("timeout_err", 32'(timeout_err), 32'(to));
      end
      // next model state
      nx = owner; wcnt_n = wcnt; last_i_n = last_i;
      hold_i_n = (owner == 1) ? e_ird : hold_i;
      hold_d_n = (owner == 2) ? e_drd : hold_d;
      to_n = to | (wcnt >= MAXW);
      if (owner == 0) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (dreq && ireq) nx = last_i ? 2 : 1;
`else
        if (dreq && ireq) nx = 2;
`endif
        else if (dreq) nx = 2;
        else if (ireq) nx = 1;
        if (nx != 0) begin
          wcnt_n = 0;
          last_i_n = (nx == 1);
        end
      end else begin
        if (e_mw) wcnt_n = (wcnt + 1 > MAXW) ? MAXW : wcnt + 1;
        else nx = 0;
        if (owner == 1 && !i_read) nx = 0;
        if (owner == 2 && !dreq) nx = 0;
      end
      owner_n = nx;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int first_mread, done_k, iw_viol, dn, idn, g, cyc, ic, dc, gcount;
    logic [31:0] got;
    logic [3:0]  gcode;
    logic        t16, t17, prev_mread, iw, dw;

    for (int k = 0; k < 256; k++) mem[k] <= 32'hA5000000 | k;
    mem[0] <= 32'h12345678;
    mem[4] <= 32'h11223344;

    // reset state
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_m_read", 32'(m_read), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_i_readdata", i_readdata, 32'd0);
    chk("rst_d_readdata", d_readdata, 32'd0);

    // lone instruction fetch, slave delay 2
    slave_delay = 2;
    tick();
    i_address = 32'hBFC00000; i_read = 1'b1;
    first_mread = -1; done_k = -1; got = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_read && first_mread < 0) first_mread = k;
      if (!i_waitrequest) begin done_k = k; got = i_readdata; break; end
    end
    tick();
    i_read = 1'b0;
    @(negedge clk);
    chk("ifetch_first_mread_cycle", first_mread, 32'd1);
    chk("ifetch_done_cycle", done_k, 32'd3);
    chk("ifetch_data", got, 32'h12345678);
    chk("ifetch_back_idle", 32'(m_read), 32'd0);

    // partial data write with a concurrent instruction fetch
    slave_delay = 1;
    tick();
    d_address = 32'h10; d_write = 1'b1; d_writedata = 32'hDEADBEEF; d_byteenable = 4'b0011;
    i_address = 32'h100; i_read = 1'b1;
    iw_viol = 0; dn = 0; idn = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!i_waitrequest) iw_viol++;
      if (!d_waitrequest) begin dn = 1; break; end
    end
    tick();
    d_write = 1'b0; d_byteenable = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!i_waitrequest) begin idn = 1; break; end
    end
    tick();
    i_read = 1'b0;
    @(negedge clk);
    chk("dwrite_done", dn, 32'd1);
    chk("dwrite_i_held", iw_viol, 32'd0);
    chk("dwrite_mem_word", mem[4], 32'h1122BEEF);
    chk("ifetch_after_d_done", idn, 32'd1);

    // simultaneous requests, four back-to-back reads on each side
    slave_delay = 0;
    tick();
    ic = 0; dc = 0; gcount = 0; gcode = '0; prev_mread = 1'b0;
    i_address = 32'h200; i_read = 1'b1;
    d_address = 32'h300; d_read = 1'b1;
    for (cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      iw = i_waitrequest; dw = d_waitrequest;
      if (m_read && !prev_mread) begin
        if (gcount < 4) gcode[3 - gcount] = (m_address[9:8] == 2'b11);
        gcount++;
      end
      prev_mread = m_read;
      tick();
      if (i_read && !iw) begin
        ic++;
        if (ic < 4) i_address = 32'h200 + 32'(4 * ic); else i_read = 1'b0;
      end
      if (d_read && !dw) begin
        dc++;
        if (dc < 4) d_address = 32'h300 + 32'(4 * dc); else d_read = 1'b0;
      end
      if (!i_read && !d_read) break;
    end
`ifdef ARB_ROUND_ROBIN_EN
    chk("grant_order_DIDI", 32'(gcode), 32'hA);
`else
    chk("grant_order_DDDD", 32'(gcode), 32'hF);
`endif
    chk("grant_count", gcount, 32'd8);

    // watchdog: slave stalls 20 cycles
    slave_delay = 20;
    tick();
    d_address = 32'h40; d_read = 1'b1;
    g = -1; t16 = 1'b1; t17 = 1'b0; dn = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (m_read && g < 0) g = cyc;
      if (g >= 0 && cyc - g == 16) t16 = timeout_err;
      if (g >= 0 && cyc - g == 17) t17 = timeout_err;
      if (!d_waitrequest) begin dn = 1; break; end
    end
    tick();
    d_read = 1'b0;
    repeat (3) @(negedge clk);
    chk("wdog_done", dn, 32'd1);
    chk("wdog_before", 32'(t16), 32'd0);
    chk("wdog_rise", 32'(t17), 32'd1);
    chk("wdog_sticky", 32'(timeout_err), 32'd1);

    // reset during a granted data write
    slave_delay = 10;
    tick();
    d_address = 32'h80; d_write = 1'b1; d_writedata = 32'h0BADF00D; d_byteenable = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_mid_granted", 32'(m_write), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_m_write", 32'(m_write), 32'd0);
    chk("rst_mid_timeout", 32'(timeout_err), 32'd0);
    chk("rst_mid_d_wait", 32'(d_waitrequest), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_idle", 32'(m_write), 32'd0);
    @(negedge clk);
    chk("rst_rel_regrant", 32'(m_write), 32'd1);
    dn = 0;
    for (int k = 0; k < 20; k++) begin
      if (!d_waitrequest) begin dn = 1; break; end
      @(negedge clk);
    end
    tick();
    d_write = 1'b0;
    chk("rst_rel_done", dn, 32'd1);

    // randomized traffic
    delay_rand = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      iw = i_waitrequest; dw = d_waitrequest;
      tick();
      if (i_read) begin
        if (!iw) begin
          if ($urandom_range(0, 1) == 1) i_address = $urandom; else i_read = 1'b0;
        end else if ($urandom_range(0, 63) == 0) i_read = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        i_read = 1'b1; i_address = $urandom;
      end
      if (d_read || d_write) begin
        if (!dw || $urandom_range(0, 63) == 0) begin
          d_read = 1'b0; d_write = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: begin d_read = 1'b1; d_write = 1'b0; end
          9:             begin d_read = 1'b1; d_write = 1'b1; end
          default:       begin d_read = 1'b0; d_write = 1'b1; end
        endcase
        d_address = $urandom; d_writedata = $urandom; d_byteenable = 4'($urandom_range(0, 15));
      end
    end
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
